uart_tx_sched: RTL



---
 rtl/uart_tx_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit scheduler between the MA-stage UART store path and the
// uart serial module. Stored bytes are queued in a circular FIFO and released
// to the uart as single-cycle write pulses, spaced by exactly one frame time.
// The uart has no busy output, so this block times each frame itself.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   st_valid  store to UART_ADDR this cycle
//   st_data   byte to transmit
//   stall     push refused this cycle (st_valid while full)
//   uart_wr   one-cycle write pulse to the uart
//   uart_dat  byte for the uart, valid while uart_wr=1, held between pulses
//   level     FIFO occupancy, 0..DEPTH
//   drained   FIFO empty and no frame in flight
//   overflow  sticky drop flag (drop mode only, else 0)
//
// Build option: define UART_TXQ_DROP_EN to never stall; pushes while full are
// discarded and set the sticky overflow flag instead.

module uart_tx_sched #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned FRAME_CYCLES = 4340,
    parameter int unsigned LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [7:0]       st_data,
    output logic             stall,
    output logic             uart_wr,
    output logic [7:0]       uart_dat,
    output logic [LVL_W-1:0] level,
    output logic             drained,
    output logic             overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    // Holds FRAME_CYCLES-1 for any FRAME_CYCLES >= 2.
    localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME_CYCLES - 1);
    // Pointers differing only in the wrap bit means full.
    localparam logic [PTR_W-1:0] PTR_MSB = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [0:0] {
        StIdle,
        StSendWait
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr, wptr_n, rptr_n;
    logic             full_q, empty_q;
    logic [CNT_W-1:0] cnt;
    state_t           state, state_n;
    logic             push, pop, drop;

    assign level = LVL_W'(wptr - rptr);

`ifdef UART_TXQ_DROP_EN
    assign stall = 1'b0;
    assign drop  = st_valid & full_q;
`else
    assign stall = st_valid & full_q;
    assign drop  = 1'b0;
`endif

    always_comb begin
        push   = st_valid & ~full_q;
        // A new frame may start from idle, or exactly when the current frame ends.
        pop    = ~empty_q & ((state == StIdle) | (cnt == '0));
        wptr_n = push ? wptr + PTR_W'(1) : wptr;
        rptr_n = pop ? rptr + PTR_W'(1) : rptr;
        if (pop) begin
            state_n = StSendWait;
        end else if ((state == StSendWait) && (cnt != '0)) begin
            state_n = StSendWait;
        end else begin
            state_n = StIdle;
        end
    end

    // Storage has no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[IDX_W-1:0]] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            state    <= StIdle;
            cnt      <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
            drained  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            empty_q  <= (wptr_n == rptr_n);
            full_q   <= ((wptr_n ^ rptr_n) == PTR_MSB);
            state    <= state_n;
            drained  <= (wptr_n == rptr_n) && (state_n == StIdle);
            overflow <= overflow | drop;
            uart_wr  <= pop;
            if (pop) begin
                uart_dat <= mem[rptr[IDX_W-1:0]];
                cnt      <= CNT_RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
